ram_req_ctrl: RTL

Request/response front-end that sits directly upstream of the small synchronous RAM and owns all of its control pins. It accepts single-word read/write requests over a valid/ready handshake, sequences the RAM's address, write-enable and write-data pins, captures the RAM read data, and returns one response per request. After reset it sweeps every RAM location to a known value before accepting traffic.

---
 rtl/ram_req_ctrl_pkg.sv | 8 +
 rtl/ram_req_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl_pkg.sv
// ram_req_ctrl_pkg: shared FSM state encoding and default geometry for ram_req_ctrl
package ram_req_ctrl_pkg;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 4;
    localparam int DEF_INIT_VAL = 0;
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_RESP} state_t;
endpackage

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: valid/ready request front-end that owns the pins of a negedge-sampling synchronous RAM
// Ports:
//   clk, rst                          clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready/req_wr/
//   req_addr/req_wdata                single-word request handshake
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err                           one response per request; err = address out of range
//   init_done                         post-reset sweep finished
//   ram_addr/ram_wr/ram_data_in/
//   ram_set_mem/ram_data_out          RAM control and data pins
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int INIT_VAL = DEF_INIT_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_set_mem,
    input  logic [DATA_W-1:0] ram_data_out
);
    // The sweep counter must reach DEPTH itself: that value marks the cycle that ends the sweep.
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] INIT_D   = DATA_W'(INIT_VAL);

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_req_ready, w_req_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic              r_init_done, w_init_done;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic              r_ram_wr, w_ram_wr;
    logic [DATA_W-1:0] r_ram_data_in, w_ram_data_in;
    logic              w_accept;
    logic              w_oob;

    assign w_accept = req_valid & r_req_ready;
    assign w_oob    = {1'b0, req_addr} >= DEPTH_A;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_INIT;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_init_done   <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wr      <= 1'b0;
            r_ram_data_in <= '0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_req_ready   <= w_req_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_init_done   <= w_init_done;
            r_ram_addr    <= w_ram_addr;
            r_ram_wr      <= w_ram_wr;
            r_ram_data_in <= w_ram_data_in;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_req_ready   = r_req_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_init_done   = r_init_done;
        w_ram_addr    = r_ram_addr;
        w_ram_wr      = r_ram_wr;
        w_ram_data_in = r_ram_data_in;
        unique case (r_state)
            S_INIT: begin
                if (r_cnt == LAST_CNT) begin
                    w_ram_wr    = 1'b0;
                    w_init_done = 1'b1;
                    w_req_ready = 1'b1;
                    w_state     = S_IDLE;
                end else begin
                    w_ram_wr      = 1'b1;
                    w_ram_addr    = ADDR_W'(r_cnt);
                    w_ram_data_in = INIT_D;
                    w_cnt         = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_accept) begin
                    w_req_ready = 1'b0;
                    if (w_oob) begin
                        // rsp_valid is raised one cycle later in RESP, matching the read/write latency.
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = '0;
                        w_state     = S_RESP;
                    end else if (req_wr) begin
                        w_ram_addr    = req_addr;
                        w_ram_data_in = req_wdata;
                        w_ram_wr      = 1'b1;
                        w_state       = S_WRITE;
                    end else begin
                        w_ram_addr = req_addr;
                        w_ram_wr   = 1'b0;
                        w_state    = S_READ;
                    end
                end
            end
            S_WRITE: begin
                w_ram_wr    = 1'b0;
                w_rsp_valid = 1'b1;
                w_rsp_err   = 1'b0;
                w_rsp_rdata = '0;
                w_state     = S_RESP;
            end
            S_READ: begin
                // RAM updated data_out at the negedge inside this cycle.
                w_rsp_rdata = ram_data_out;
                w_rsp_valid = 1'b1;
                w_rsp_err   = 1'b0;
                w_state     = S_RESP;
            end
            S_RESP: begin
                if (!r_rsp_valid) begin
                    w_rsp_valid = 1'b1;
                end else if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_INIT;
        endcase
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign init_done   = r_init_done;
    assign ram_addr    = r_ram_addr;
    assign ram_wr      = r_ram_wr;
    assign ram_data_in = r_ram_data_in;
    assign ram_set_mem = 1'b1;
endmodule
